avalon_mem_arbiter: RTL and testbench
=====================================

Name: avalon_mem_arbiter

Overview:
Two-master round-robin arbiter that shares one Avalon-MM memory slave: the 64-bit, 12-bit-address wrapper with split-half writes. Each master has its own Avalon-MM port with waitrequest and readdatavalid. The arbiter keeps the slave's two-beat write sequence (low half with byteenable 8'h0F, then high half with 8'hF0) atomic per master. It returns read data to the master that issued the read.

Parameters:
RD_LATENCY, 2, cycles from slave read acceptance (s_read=1 and s_waitrequest=0) to valid s_readdata; legal range 1..4.
ADDR_W, 12, address width.
DATA_W, 64, data width; byteenable width is DATA_W/8.

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
m0_address  in  ADDR_W  master 0 address.
m0_writedata  in  DATA_W  master 0 write data.
m0_write  in  1  master 0 write request.
m0_read  in  1  master 0 read request.
m0_byteenable  in  DATA_W/8  master 0 byte enables.
m0_readdata  out  DATA_W  read data to master 0.
m0_readdatavalid  out  1  m0_readdata valid this cycle.
m0_waitrequest  out  1  stall to master 0.
m1_*  same eight signals for master 1.
s_address  out  ADDR_W  to slave.
s_writedata  out  DATA_W  to slave.
s_write  out  1  to slave.
s_read  out  1  to slave.
s_byteenable  out  DATA_W/8  to slave.
s_readdata  in  DATA_W  from slave.
s_waitrequest  in  1  from slave.

Behaviour:
- Registers: gnt (NONE/M0/M1), last (last master served, reset M1 so M0 wins first tie), lock (1 bit), rd pipe (RD_LATENCY entries of {valid, id}).
- Reset: gnt=NONE, lock=0, last=M1, rd pipe cleared. A reset mid-transfer drops any pending lock and any in-flight read returns; no readdatavalid pulses after reset.
- Requests: req_i = mi_read | mi_write. Masters must hold all request signals stable while mi_waitrequest=1.
- Arbitration (gnt=NONE):
  - Only one master requesting: that master is granted next cycle.
  - Both requesting: the master other than last is granted.
  - Arbitration costs one cycle: mi_waitrequest=1 in the arbitration cycle.
- Granted (gnt=Mi):
  - s_* mirror mi_* combinationally.
  - mi_waitrequest = s_waitrequest.
  - The other master's waitrequest = 1 whenever it requests, 0 otherwise.
  - gnt=NONE: s_read=s_write=0; s_address, s_writedata and s_byteenable are 0.
- Completion: the cycle where (s_read|s_write)=1 and s_waitrequest=0.
  - Write with byteenable 8'h0F: lock<=1, gnt held.
  - Write with 8'hF0: lock<=0, gnt<=NONE, last<=i.
  - Any other write, or any read: if lock=0, gnt<=NONE, last<=i; if lock=1, gnt held.
- Lock: while lock=1 the other master is never granted, even if the owner issues reads between the halves. There is no timeout.
- Abandon: if gnt=Mi, lock=0 and req_i=0, then gnt<=NONE and last is unchanged.
- Read return:
  - An accepted read pushes {1,i} into the rd pipe.
  - After exactly RD_LATENCY cycles, mi_readdatavalid=1 for one cycle with mi_readdata=s_readdata.
  - Both mX_readdata buses always carry s_readdata; only readdatavalid is routed.
  - Reads from different masters return in issue order; the pipe never stalls.
- Simultaneous events:
  - A new request on the completion cycle waits for the next arbitration cycle; there are no back-to-back grants without a NONE cycle.
  - Pipe pop and push in the same cycle are both honoured.
- Throughput: one transfer per two cycles per grant, plus any slave waitrequest cycles.

Test Plan:
- Single read: m0 reads 0x010, slave returns 0xDEAD_BEEF_0000_0001 after 2 cycles -> m0_waitrequest high 1 cycle (arbitration), then high while slave stalls; m0_readdatavalid pulses once, RD_LATENCY=2 after acceptance; m1_readdatavalid stays 0.
- Tie: m0 and m1 read together from reset -> m0 served first, then m1; next tie -> m0 first (alternation after m1 served).
- Locked write pair: m1 writes 0x020 with be 8'h0F, then be 8'hF0, while m0 holds a read -> m0 is not granted until the cycle after the 8'hF0 write completes; slave sees the two halves contiguously from m1.
- Interleaved reads: m0 read 0x001, then m1 read 0x002 on consecutive grants -> readdatavalid returns in order m0 then m1, each RD_LATENCY after its acceptance, with the correct data.
- Reset mid-lock: assert reset after m0's 8'h0F half -> lock=0, gnt=NONE; m1 granted on its first request after reset.
- Abandon: m1 granted, drops its request before acceptance -> gnt returns to NONE, last unchanged, and m0 is then granted.

Source files
------------

// File: rtl/avalon_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single Avalon-MM memory slave.
// Keeps a master's low-half/high-half write pair atomic and routes
// read returns back to the master that issued each read.
module avalon_mem_arbiter #(
  parameter int RD_LATENCY = 2,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W-1:0]     m0_writedata,
  input  logic                  m0_write,
  input  logic                  m0_read,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  output logic                  m0_waitrequest,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W-1:0]     m1_writedata,
  input  logic                  m1_write,
  input  logic                  m1_read,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic                  m1_waitrequest,
  output logic [ADDR_W-1:0]     s_address,
  output logic [DATA_W-1:0]     s_writedata,
  output logic                  s_write,
  output logic                  s_read,
  output logic [DATA_W/8-1:0]   s_byteenable,
  input  logic [DATA_W-1:0]     s_readdata,
  input  logic                  s_waitrequest
);

  localparam int BE_W = DATA_W / 8;
  // Low-half byte enables open the atomic pair, high-half ones close it.
  localparam logic [BE_W-1:0] BE_LO = {{(BE_W/2){1'b0}}, {(BE_W/2){1'b1}}};
  localparam logic [BE_W-1:0] BE_HI = ~BE_LO;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  logic [1:0]            gnt_reg;
  logic                  last_reg;   // 0 = m0 served last, 1 = m1 served last
  logic                  lock_reg;
  logic [RD_LATENCY-1:0] rd_valid_reg;
  logic [RD_LATENCY-1:0] rd_id_reg;

  logic req0, req1, sel0, sel1;
  logic xfer_done, done_id, rd_push, owner_req;

  assign req0      = m0_read | m0_write;
  assign req1      = m1_read | m1_write;
  assign sel0      = (gnt_reg == GNT_M0);
  assign sel1      = (gnt_reg == GNT_M1);
  assign owner_req = sel1 ? req1 : req0;

  // Slave side mirrors the granted master; everything is zero when idle.
  always_comb begin
    s_address    = '0;
    s_writedata  = '0;
    s_write      = 1'b0;
    s_read       = 1'b0;
    s_byteenable = '0;
    if (sel0) begin
      s_address    = m0_address;
      s_writedata  = m0_writedata;
      s_write      = m0_write;
      s_read       = m0_read;
      s_byteenable = m0_byteenable;
    end else if (sel1) begin
      s_address    = m1_address;
      s_writedata  = m1_writedata;
      s_write      = m1_write;
      s_read       = m1_read;
      s_byteenable = m1_byteenable;
    end
  end

  // A non-granted master is stalled only while it actually requests.
  assign m0_waitrequest = sel0 ? s_waitrequest : req0;
  assign m1_waitrequest = sel1 ? s_waitrequest : req1;

  assign xfer_done = (s_read | s_write) & ~s_waitrequest;
  assign done_id   = sel1;
  assign rd_push   = xfer_done & s_read;

  // Grant / lock / round-robin history.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_reg  <= GNT_NONE;
      last_reg <= 1'b1;
      lock_reg <= 1'b0;
    end else if (gnt_reg == GNT_NONE) begin
      if (req0 && req1) begin
        gnt_reg <= last_reg ? GNT_M0 : GNT_M1;
      end else if (req0) begin
        gnt_reg <= GNT_M0;
      end else if (req1) begin
        gnt_reg <= GNT_M1;
      end
    end else if (xfer_done) begin
      if (s_write && (s_byteenable == BE_LO)) begin
        lock_reg <= 1'b1;
      end else if (s_write && (s_byteenable == BE_HI)) begin
        lock_reg <= 1'b0;
        gnt_reg  <= GNT_NONE;
        last_reg <= done_id;
      end else if (!lock_reg) begin
        gnt_reg  <= GNT_NONE;
        last_reg <= done_id;
      end
    end else if (!lock_reg && !owner_req) begin
      // Owner withdrew before acceptance: release without touching history.
      gnt_reg <= GNT_NONE;
    end
  end

  // Read-return tag pipe: stage k holds reads accepted k+1 cycles ago.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_reg <= '0;
      rd_id_reg    <= '0;
    end else begin
      rd_valid_reg[0] <= rd_push;
      rd_id_reg[0]    <= done_id;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_valid_reg[i] <= rd_valid_reg[i-1];
        rd_id_reg[i]    <= rd_id_reg[i-1];
      end
    end
  end

  assign m0_readdatavalid = rd_valid_reg[RD_LATENCY-1] & ~rd_id_reg[RD_LATENCY-1];
  assign m1_readdatavalid = rd_valid_reg[RD_LATENCY-1] &  rd_id_reg[RD_LATENCY-1];
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Bench for avalon_mem_arbiter: directed scenarios plus a random phase,
// scored against a transaction-level model of two masters and a memory slave.
module tb_avalon_mem_arbiter;
  localparam int L  = 2;
  localparam int AW = 12;
  localparam int DW = 64;
  localparam int BW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic [AW-1:0] m0_address = '0, m1_address = '0, s_address;
  logic [DW-1:0] m0_writedata = '0, m1_writedata = '0, s_writedata;
  logic          m0_write = 1'b0, m0_read = 1'b0, m1_write = 1'b0, m1_read = 1'b0;
  logic [BW-1:0] m0_byteenable = '0, m1_byteenable = '0, s_byteenable;
  logic [DW-1:0] m0_readdata, m1_readdata, s_readdata = '0;
  logic          m0_readdatavalid, m1_readdatavalid, m0_waitrequest, m1_waitrequest;
  logic          s_write, s_read, s_waitrequest = 1'b0;

  avalon_mem_arbiter #(.RD_LATENCY(L), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_writedata(m0_writedata), .m0_write(m0_write),
    .m0_read(m0_read), .m0_byteenable(m0_byteenable), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_writedata(m1_writedata), .m1_write(m1_write),
    .m1_read(m1_read), .m1_byteenable(m1_byteenable), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_writedata(s_writedata), .s_write(s_write),
    .s_read(s_read), .s_byteenable(s_byteenable), .s_readdata(s_readdata),
    .s_waitrequest(s_waitrequest)
  );

  typedef struct { bit wr; logic [AW-1:0] addr; logic [DW-1:0] data; logic [BW-1:0] be; } op_t;
  typedef struct { int due; logic [DW-1:0] data; } ret_t;

  op_t  mq0[$], mq1[$];            // pending ops per master, head is on the bus
  ret_t exp0[$], exp1[$], slv[$];  // expected returns per master, slave return schedule
  logic [DW-1:0] mem [4096];
  int acc_m[$], acc_c[$], rdv_m[$], rdv_c[$];
  logic [DW-1:0] rdv_d[$];
  int checks = 0, errors = 0, cyc = 0;
  int age0 = 0, age1 = 0, lock_owner = -1, owed = -1, prev_end = -10;
  bit force_stall = 1'b0, rand_stall = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk(input bit wr, input int addr, input logic [DW-1:0] d, input logic [BW-1:0] be);
    op_t o;
    o.wr = wr; o.addr = AW'(addr); o.data = d; o.be = be;
    return o;
  endfunction

  task automatic drive_masters();
    if (mq0.size() > 0) begin
      m0_read = !mq0[0].wr; m0_write = mq0[0].wr; m0_address = mq0[0].addr;
      m0_writedata = mq0[0].data; m0_byteenable = mq0[0].be;
    end else begin
      m0_read = 1'b0; m0_write = 1'b0; m0_address = AW'($urandom);
      m0_writedata = {$urandom, $urandom}; m0_byteenable = BW'($urandom);
    end
    if (mq1.size() > 0) begin
      m1_read = !mq1[0].wr; m1_write = mq1[0].wr; m1_address = mq1[0].addr;
      m1_writedata = mq1[0].data; m1_byteenable = mq1[0].be;
    end else begin
      m1_read = 1'b0; m1_write = 1'b0; m1_address = AW'($urandom);
      m1_writedata = {$urandom, $urandom}; m1_byteenable = BW'($urandom);
    end
  endtask

  // One clock cycle: drive after the edge, settle, then score the cycle.
  task automatic step(input bit rst);
    logic rq0, rq1, a0, a1, sa, ev0, ev1;
    int i;
    op_t op;
    @(posedge clk);
    #1;
    reset = rst;
    drive_masters();
    s_waitrequest = force_stall | (rand_stall && ($urandom_range(0, 3) == 0));
    s_readdata = {$urandom, $urandom};
    if (slv.size() > 0 && slv[0].due == cyc) begin
      s_readdata = slv[0].data;
      void'(slv.pop_front());
    end
    #1;
    if (rst) begin
      exp0.delete(); exp1.delete();
      lock_owner = -1; owed = -1; prev_end = -10; age0 = 0; age1 = 0;
    end else begin
      rq0 = m0_read | m0_write;
      rq1 = m1_read | m1_write;
      if (owed == 0 && !rq0) owed = -1;
      if (owed == 1 && !rq1) owed = -1;
      if (rq0 && age0 == 0 && lock_owner != 0) chk("arb_wait_m0", m0_waitrequest, 1);
      if (rq1 && age1 == 0 && lock_owner != 1) chk("arb_wait_m1", m1_waitrequest, 1);
      a0 = rq0 && !m0_waitrequest;
      a1 = rq1 && !m1_waitrequest;
      sa = (s_read | s_write) && !s_waitrequest;
      chk("one_grant", a0 && a1, 0);
      chk("slave_accept", sa, a0 | a1);
      if (a0 ^ a1) begin
        i  = a1 ? 1 : 0;
        op = a1 ? mq1[0] : mq0[0];
        chk("s_write", s_write, op.wr);
        chk("s_read", s_read, !op.wr);
        chk("s_address", s_address, op.addr);
        chk("s_byteenable", s_byteenable, op.be);
        if (op.wr) chk("s_writedata", s_writedata, op.data);
        if (lock_owner >= 0) chk("lock_hold", i, lock_owner);
        if (owed >= 0) begin
          chk("round_robin", i, owed);
          owed = -1;
        end
        chk("idle_gap", (cyc - prev_end) > 1, 1);
        acc_m.push_back(i); acc_c.push_back(cyc);
        if (!op.wr) begin
          ret_t r;
          r.due = cyc + L; r.data = mem[op.addr];
          slv.push_back(r);
          if (i == 0) exp0.push_back(r); else exp1.push_back(r);
        end else begin
          for (int b = 0; b < BW; b++)
            if (op.be[b]) mem[op.addr][8*b +: 8] = op.data[8*b +: 8];
          if (op.be == 8'h0F) lock_owner = i;
          else if (op.be == 8'hF0) lock_owner = -1;
        end
        if (lock_owner < 0) begin
          prev_end = cyc;
          if ((i == 0) ? rq1 : rq0) owed = 1 - i;
        end
        if (i == 0) begin void'(mq0.pop_front()); age0 = 0; end
        else begin void'(mq1.pop_front()); age1 = 0; end
      end
      if (rq0 && !a0) age0++;
      if (rq1 && !a1) age1++;
      ev0 = (exp0.size() > 0) && (exp0[0].due == cyc);
      ev1 = (exp1.size() > 0) && (exp1[0].due == cyc);
      chk("rdvalid_m0", m0_readdatavalid, ev0);
      chk("rdvalid_m1", m1_readdatavalid, ev1);
      if (ev0) begin
        chk("rddata_m0", m0_readdata, exp0[0].data);
        rdv_m.push_back(0); rdv_c.push_back(cyc); rdv_d.push_back(exp0[0].data);
        void'(exp0.pop_front());
      end
      if (ev1) begin
        chk("rddata_m1", m1_readdata, exp1[0].data);
        rdv_m.push_back(1); rdv_c.push_back(cyc); rdv_d.push_back(exp1[0].data);
        void'(exp1.pop_front());
      end
    end
    cyc++;
  endtask

  function automatic bit busy();
    return (mq0.size() + mq1.size() + exp0.size() + exp1.size()) != 0;
  endfunction

  task automatic run_until_idle(input string tag);
    int n = 0;
    while (busy() && n < 300) begin
      step(1'b0);
      n++;
    end
    chk(tag, busy(), 0);
  endtask

  task automatic clear_logs();
    acc_m.delete(); acc_c.delete(); rdv_m.delete(); rdv_c.delete(); rdv_d.delete();
  endtask

  // Directed scenarios followed by a random phase.
  initial begin
    logic [DW-1:0] w1, w2;
    int n;
    for (int a = 0; a < 4096; a++) mem[a] = {$urandom, $urandom};
    mem[12'h010] = 64'hDEAD_BEEF_0000_0001;
    mem[12'h001] = 64'h1111_2222_3333_0001;
    mem[12'h002] = 64'h4444_5555_6666_0002;

    // Reset state
    step(1'b1); step(1'b1); step(1'b1);
    step(1'b0);
    chk("rst_s_read", s_read, 0);
    chk("rst_s_write", s_write, 0);
    chk("rst_s_address", s_address, 0);
    chk("rst_s_writedata", s_writedata, 0);
    chk("rst_s_be", s_byteenable, 0);
    chk("rst_m0_wait", m0_waitrequest, 0);
    chk("rst_m1_wait", m1_waitrequest, 0);

    // Single read with one slave stall cycle
    clear_logs();
    mq0.push_back(mk(1'b0, 'h010, '0, 8'hFF));
    force_stall = 1'b1;
    step(1'b0);
    chk("t1_arb_wait", m0_waitrequest, 1);
    chk("t1_arb_s_read", s_read, 0);
    step(1'b0);
    chk("t1_stall_wait", m0_waitrequest, 1);
    chk("t1_s_read", s_read, 1);
    chk("t1_s_address", s_address, 'h010);
    force_stall = 1'b0;
    step(1'b0);
    chk("t1_accept", m0_waitrequest, 0);
    step(1'b0);
    chk("t1_early_valid", m0_readdatavalid, 0);
    step(1'b0);
    chk("t1_valid", m0_readdatavalid, 1);
    chk("t1_data", m0_readdata, 64'hDEAD_BEEF_0000_0001);
    chk("t1_m1_valid", m1_readdatavalid, 0);
    step(1'b0);
    chk("t1_pulses", rdv_m.size(), 1);

    // Ties: from reset m0 first, then m0 again, then m1 after m0 was served
    step(1'b1);
    clear_logs();
    mq0.push_back(mk(1'b0, 'h100, '0, 8'hFF));
    mq1.push_back(mk(1'b0, 'h101, '0, 8'hFF));
    run_until_idle("t2_drain_a");
    chk("t2_tie1_first", acc_m[0], 0);
    chk("t2_tie1_second", acc_m[1], 1);
    clear_logs();
    mq0.push_back(mk(1'b0, 'h102, '0, 8'hFF));
    mq1.push_back(mk(1'b0, 'h103, '0, 8'hFF));
    run_until_idle("t2_drain_b");
    chk("t2_tie2_first", acc_m[0], 0);
    mq0.push_back(mk(1'b0, 'h104, '0, 8'hFF));
    run_until_idle("t2_drain_c");
    clear_logs();
    mq0.push_back(mk(1'b0, 'h105, '0, 8'hFF));
    mq1.push_back(mk(1'b0, 'h106, '0, 8'hFF));
    run_until_idle("t2_drain_d");
    chk("t2_tie3_first", acc_m[0], 1);

    // Locked write pair from m1 while m0 waits to read the same word
    clear_logs();
    w1 = {$urandom, $urandom};
    w2 = {$urandom, $urandom};
    mq1.push_back(mk(1'b1, 'h020, w1, 8'h0F));
    mq1.push_back(mk(1'b1, 'h020, w2, 8'hF0));
    mq0.push_back(mk(1'b0, 'h020, '0, 8'hFF));
    run_until_idle("t3_drain");
    chk("t3_order0", acc_m[0], 1);
    chk("t3_order1", acc_m[1], 1);
    chk("t3_order2", acc_m[2], 0);
    chk("t3_contiguous", acc_c[1] - acc_c[0], 1);
    chk("t3_m0_after", acc_c[2] - acc_c[1], 2);
    chk("t3_merged", rdv_d[0], {w2[63:32], w1[31:0]});

    // Interleaved reads on consecutive grants
    clear_logs();
    mq0.push_back(mk(1'b0, 'h001, '0, 8'hFF));
    step(1'b0);
    mq1.push_back(mk(1'b0, 'h002, '0, 8'hFF));
    run_until_idle("t4_drain");
    chk("t4_ret_first", rdv_m[0], 0);
    chk("t4_ret_second", rdv_m[1], 1);
    chk("t4_lat_m0", rdv_c[0] - acc_c[0], L);
    chk("t4_lat_m1", rdv_c[1] - acc_c[1], L);
    chk("t4_data_m0", rdv_d[0], 64'h1111_2222_3333_0001);
    chk("t4_data_m1", rdv_d[1], 64'h4444_5555_6666_0002);

    // Reset after m0's low half plus an in-flight read
    clear_logs();
    mq0.push_back(mk(1'b1, 'h030, {$urandom, $urandom}, 8'h0F));
    mq0.push_back(mk(1'b0, 'h031, '0, 8'hFF));
    n = 0;
    while (acc_m.size() < 2 && n < 20) begin step(1'b0); n++; end
    chk("t5_pre_accepts", acc_m.size(), 2);
    step(1'b1);
    mq1.push_back(mk(1'b0, 'h032, '0, 8'hFF));
    step(1'b0);
    chk("t5_m1_arb", m1_waitrequest, 1);
    chk("t5_no_stale_valid", m0_readdatavalid, 0);
    step(1'b0);
    chk("t5_m1_granted", m1_waitrequest, 0);
    run_until_idle("t5_drain");
    chk("t5_pulses", rdv_m.size(), 1);

    // Abandon: m1 withdraws while stalled, m0 then wins
    mq1.push_back(mk(1'b0, 'h040, '0, 8'hFF));
    force_stall = 1'b1;
    step(1'b0);
    chk("t6_arb", m1_waitrequest, 1);
    step(1'b0);
    chk("t6_s_address", s_address, 'h040);
    void'(mq1.pop_front()); age1 = 0;
    mq0.push_back(mk(1'b0, 'h041, '0, 8'hFF));
    step(1'b0);
    chk("t6_m0_held", m0_waitrequest, 1);
    chk("t6_s_read_idle", s_read, 0);
    force_stall = 1'b0;
    step(1'b0);
    chk("t6_m0_arb", m0_waitrequest, 1);
    step(1'b0);
    chk("t6_m0_granted", m0_waitrequest, 0);
    run_until_idle("t6_drain_a");
    // Abandon again with m0 served last; history must not change
    mq1.push_back(mk(1'b0, 'h042, '0, 8'hFF));
    force_stall = 1'b1;
    step(1'b0);
    step(1'b0);
    chk("t6b_s_address", s_address, 'h042);
    void'(mq1.pop_front()); age1 = 0;
    step(1'b0);
    force_stall = 1'b0;
    clear_logs();
    mq0.push_back(mk(1'b0, 'h043, '0, 8'hFF));
    mq1.push_back(mk(1'b0, 'h044, '0, 8'hFF));
    run_until_idle("t6_drain_b");
    chk("t6b_tie_first", acc_m[0], 1);

    // Random traffic with slave stalls
    rand_stall = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      for (int m = 0; m < 2; m++) begin
        if (((m == 0) ? mq0.size() : mq1.size()) == 0 && $urandom_range(0, 2) == 0) begin
          int kind;
          int a;
          logic [BW-1:0] be;
          op_t o1, o2, o3;
          kind = $urandom_range(0, 2);
          a = $urandom_range(0, 15);
          be = BW'($urandom);
          if (be == 8'h0F || be == 8'hF0) be = 8'hFF;
          o1 = (kind == 0) ? mk(1'b0, a, '0, 8'hFF)
             : (kind == 1) ? mk(1'b1, a, {$urandom, $urandom}, be)
             : mk(1'b1, a, {$urandom, $urandom}, 8'h0F);
          o2 = mk(1'b0, $urandom_range(0, 15), '0, 8'hFF);
          o3 = mk(1'b1, a, {$urandom, $urandom}, 8'hF0);
          if (m == 0) begin
            mq0.push_back(o1);
            if (kind == 2) begin
              if ($urandom_range(0, 1) == 1) mq0.push_back(o2);
              mq0.push_back(o3);
            end
          end else begin
            mq1.push_back(o1);
            if (kind == 2) begin
              if ($urandom_range(0, 1) == 1) mq1.push_back(o2);
              mq1.push_back(o3);
            end
          end
        end
      end
      step(1'b0);
    end
    run_until_idle("rand_drain");
    chk("rand_lock_clear", lock_owner, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
